alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare unit.
- Uses round-robin arbitration with an optional lock that lets one requester issue back-to-back operations.
- Drives the ALU operand and op inputs from the granted requester.
- Registers the ALU result and flags into a one-entry response buffer per requester, using valid/ready handshakes on both sides.

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
// Round-robin grant with an optional bounded lock and per-requester result buffers.

package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_CMP
    } ALU_OPS_T;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic negative;
        logic zero;
    } FLAGS_T;

endpackage

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_lock,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  ALU_OPS_T    req_op0,
    input  ALU_OPS_T    req_op1,
    output logic [15:0] alu_in_a,
    output logic [15:0] alu_in_b,
    output ALU_OPS_T    alu_op,
    input  logic [15:0] alu_out,
    input  FLAGS_T      alu_flags,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [15:0] resp_data0,
    output logic [15:0] resp_data1,
    output FLAGS_T      resp_flags0,
    output FLAGS_T      resp_flags1,
    output logic [1:0]  lock_owner
);

    typedef enum logic [1:0] {
        ARB,
        LOCKED0,
        LOCKED1
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic        last_grant;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        acc;
    logic        idx;

    // A full buffer that is being drained this cycle can take a new result.
    assign elig = req_valid & (~resp_valid | resp_ready);

    assign acc = |grant;
    assign idx = grant[1];

    assign req_ready  = grant;
    assign lock_owner = {state == LOCKED1, state == LOCKED0};

    // One-hot grant: owner only while locked, otherwise round-robin on ties.
    always_comb begin
        grant = 2'b00;
        case (state)
            ARB: begin
                if (elig == 2'b11) begin
                    grant = last_grant ? 2'b01 : 2'b10;
                end else begin
                    grant = elig;
                end
            end
            LOCKED0: grant = {1'b0, elig[0]};
            LOCKED1: grant = {elig[1], 1'b0};
            default: grant = 2'b00;
        endcase
    end

    // Steer the granted requester's operands onto the shared ALU.
    always_comb begin
        alu_in_a = 16'h0000;
        alu_in_b = 16'h0000;
        alu_op   = ALU_ADD;
        unique case (1'b1)
            grant[0]: begin
                alu_in_a = req_a0;
                alu_in_b = req_b0;
                alu_op   = req_op0;
            end
            grant[1]: begin
                alu_in_a = req_a1;
                alu_in_b = req_b1;
                alu_op   = req_op1;
            end
            default: ;
        endcase
    end

    // Lock state only moves on an accept; the entering accept counts toward LOCK_MAX.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (acc) begin
            case (state)
                ARB: begin
                    if (req_lock[idx] && LOCK_MAX > 1) begin
                        state_n = idx ? LOCKED1 : LOCKED0;
                        cnt_n   = 4'd1;
                    end
                end
                LOCKED0, LOCKED1: begin
                    if (req_lock[idx] && (32'(cnt) + 32'd1) < LOCK_MAX) begin
                        cnt_n = cnt + 4'd1;
                    end else begin
                        state_n = ARB;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = ARB;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // Arbitration state, lock counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARB;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (acc) begin
                last_grant <= idx;
            end
        end
    end

    // One-entry response buffers; an accept reloads even while draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid  <= 2'b00;
            resp_data0  <= 16'h0000;
            resp_data1  <= 16'h0000;
            resp_flags0 <= FLAGS_T'(0);
            resp_flags1 <= FLAGS_T'(0);
        end else begin
            if (grant[0]) begin
                resp_valid[0] <= 1'b1;
                resp_data0    <= alu_out;
                resp_flags0   <= alu_flags;
            end else if (resp_ready[0]) begin
                resp_valid[0] <= 1'b0;
            end
            if (grant[1]) begin
                resp_valid[1] <= 1'b1;
                resp_data1    <= alu_out;
                resp_flags1   <= alu_flags;
            end else if (resp_ready[1]) begin
                resp_valid[1] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven bench for alu_arbiter with an ALU model
// and per-requester result scoreboards.

module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_lock;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    ALU_OPS_T    req_op0, req_op1;
    logic [15:0] alu_in_a, alu_in_b;
    ALU_OPS_T    alu_op;
    logic [15:0] alu_out;
    FLAGS_T      alu_flags;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_data0, resp_data1;
    FLAGS_T      resp_flags0, resp_flags1;
    logic [1:0]  lock_owner;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] data;
        FLAGS_T      flags;
    } res_t;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  lk;
        logic [15:0] a0;
        logic [15:0] b0;
        ALU_OPS_T    op0;
        logic [15:0] a1;
        logic [15:0] b1;
        ALU_OPS_T    op1;
        logic [1:0]  rr;
        logic [1:0]  er;
        logic [1:0]  eo;
        int          hc;
    } vec_t;

    res_t       q0[$];
    res_t       q1[$];
    logic [1:0] exp_rv;
    vec_t       vecs[$];
    res_t       ar;

    alu_arbiter #(.LOCK_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lock   (req_lock),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data0 (resp_data0),
        .resp_data1 (resp_data1),
        .resp_flags0(resp_flags0),
        .resp_flags1(resp_flags1),
        .lock_owner (lock_owner)
    );

    always #5 clk = ~clk;

    function automatic res_t alu_model(logic [15:0] a, logic [15:0] b,
                                       ALU_OPS_T op);
        logic [16:0] s;
        res_t        r;
        r = '0;
        s = '0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r.data = s[15:0];
                r.flags.carry = s[16];
                r.flags.overflow = (a[15] == b[15]) && (s[15] != a[15]);
            end
            ALU_SUB, ALU_CMP: begin
                s = {1'b0, a} - {1'b0, b};
                r.data = s[15:0];
                r.flags.carry = s[16];
                r.flags.overflow = (a[15] != b[15]) && (s[15] != a[15]);
            end
            ALU_AND: r.data = a & b;
            ALU_OR:  r.data = a | b;
            ALU_XOR: r.data = a ^ b;
            default: r.data = 16'h0000;
        endcase
        r.flags.negative = r.data[15];
        r.flags.zero = (r.data == 16'h0000);
        return r;
    endfunction

    always_comb begin
        ar = alu_model(alu_in_a, alu_in_b, alu_op);
        alu_out = ar.data;
        alu_flags = ar.flags;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] v, logic [1:0] lk,
                                logic [15:0] a0, logic [15:0] b0,
                                ALU_OPS_T op0, logic [15:0] a1,
                                logic [15:0] b1, ALU_OPS_T op1,
                                logic [1:0] rr, logic [1:0] er,
                                logic [1:0] eo, int hc);
        vec_t t;
        t.v = v; t.lk = lk;
        t.a0 = a0; t.b0 = b0; t.op0 = op0;
        t.a1 = a1; t.b1 = b1; t.op1 = op1;
        t.rr = rr; t.er = er; t.eo = eo; t.hc = hc;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_lock = 2'b00;
        resp_ready = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        exp_rv = 2'b00;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_lock_owner", 32'(lock_owner), 32'h0);
        chk("rst_resp_data0", 32'(resp_data0), 32'h0);
        chk("rst_resp_data1", 32'(resp_data1), 32'h0);
        chk("rst_resp_flags0", 32'(resp_flags0), 32'h0);
        chk("rst_resp_flags1", 32'(resp_flags1), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    endtask

    task automatic step(vec_t t);
        res_t e;
        @(negedge clk);
        req_valid = t.v;
        req_lock = t.lk;
        req_a0 = t.a0; req_b0 = t.b0; req_op0 = t.op0;
        req_a1 = t.a1; req_b1 = t.b1; req_op1 = t.op1;
        resp_ready = t.rr;
        #1;
        chk("req_ready", 32'(req_ready), 32'(t.er));
        chk("lock_owner", 32'(lock_owner), 32'(t.eo));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (t.er == 2'b01) begin
            chk("alu_in_a", 32'(alu_in_a), 32'(t.a0));
            chk("alu_in_b", 32'(alu_in_b), 32'(t.b0));
            chk("alu_op", 32'(alu_op), 32'(t.op0));
        end else if (t.er == 2'b10) begin
            chk("alu_in_a", 32'(alu_in_a), 32'(t.a1));
            chk("alu_in_b", 32'(alu_in_b), 32'(t.b1));
            chk("alu_op", 32'(alu_op), 32'(t.op1));
        end else begin
            chk("idle_alu_a", 32'(alu_in_a), 32'h0);
            chk("idle_alu_op", 32'(alu_op), 32'(ALU_ADD));
        end
        if (exp_rv[0] && t.rr[0]) begin
            if (q0.size() == 0) begin
                chk("q0_empty", 32'h1, 32'h0);
            end else begin
                e = q0.pop_front();
                chk("resp_data0", 32'(resp_data0), 32'(e.data));
                chk("resp_flags0", 32'(resp_flags0), 32'(e.flags));
            end
        end
        if (exp_rv[1] && t.rr[1]) begin
            if (q1.size() == 0) begin
                chk("q1_empty", 32'h1, 32'h0);
            end else begin
                e = q1.pop_front();
                chk("resp_data1", 32'(resp_data1), 32'(e.data));
                chk("resp_flags1", 32'(resp_flags1), 32'(e.flags));
            end
        end
        if (t.er[0]) q0.push_back(alu_model(t.a0, t.b0, t.op0));
        if (t.er[1]) q1.push_back(alu_model(t.a1, t.b1, t.op1));
        for (int i = 0; i < 2; i++) begin
            if (t.er[i]) exp_rv[i] = 1'b1;
            else if (t.rr[i]) exp_rv[i] = 1'b0;
        end
        @(posedge clk);
        #2;
        case (t.hc)
            1: begin
                chk("add_ovf_valid", 32'(resp_valid), 32'h1);
                chk("add_ovf_data", 32'(resp_data0), 32'h8000);
                chk("add_ovf_flags", 32'(resp_flags0), 32'h6);
            end
            3: begin
                chk("reload_valid0", 32'(resp_valid[0]), 32'h1);
                chk("reload_data0", 32'(resp_data0), 32'h0123);
            end
            4: begin
                chk("cmp_data", 32'(resp_data1), 32'hFFFE);
                chk("cmp_flags", 32'(resp_flags1), 32'hA);
            end
            5: begin
                chk("pre_rst_valid", 32'(resp_valid), 32'h3);
                chk("pre_rst_owner", 32'(lock_owner), 32'h2);
                do_reset();
            end
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_lock = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = ALU_ADD;
        req_a1 = '0; req_b1 = '0; req_op1 = ALU_ADD;
        resp_ready = 2'b00;
        exp_rv = 2'b00;
        repeat (2) @(posedge clk);
        do_reset();

        vecs.push_back(mk(2'b01, 2'b00, 16'h7FFF, 16'h0001, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b11, 2'b01, 2'b00, 1));
        vecs.push_back(mk(2'b11, 2'b00, 16'h1234, 16'h1111, ALU_SUB,
                          16'h00F0, 16'h0FF0, ALU_AND, 2'b11, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'hAAAA, 16'h5555, ALU_OR,
                          16'h0F0F, 16'h00FF, ALU_XOR, 2'b11, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'h0001, 16'h0002, ALU_ADD,
                          16'hFFFF, 16'h0001, ALU_ADD, 2'b11, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'h8000, 16'h0001, ALU_SUB,
                          16'h0002, 16'h0002, ALU_SUB, 2'b11, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b10, 2'b00, 16'h0000, 16'h0000, ALU_ADD,
                          16'h0001, 16'h0002, ALU_XOR, 2'b11, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b01, 16'h0010, 16'h0001, ALU_ADD,
                          16'h0005, 16'h0005, ALU_ADD, 2'b11, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b01, 16'h0020, 16'h0002, ALU_ADD,
                          16'h0006, 16'h0005, ALU_ADD, 2'b11, 2'b01, 2'b01, 0));
        vecs.push_back(mk(2'b11, 2'b01, 16'h0030, 16'h0003, ALU_SUB,
                          16'h0007, 16'h0005, ALU_ADD, 2'b11, 2'b01, 2'b01, 0));
        vecs.push_back(mk(2'b11, 2'b01, 16'h0040, 16'h00FF, ALU_AND,
                          16'h0008, 16'h0005, ALU_ADD, 2'b11, 2'b01, 2'b01, 0));
        vecs.push_back(mk(2'b11, 2'b01, 16'h0050, 16'h0005, ALU_ADD,
                          16'h0009, 16'h0005, ALU_SUB, 2'b11, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0011, 16'h0022, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b10, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'h0033, 16'h0044, ALU_ADD,
                          16'h1000, 16'h0100, ALU_OR, 2'b10, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'h0033, 16'h0044, ALU_ADD,
                          16'h2000, 16'h0200, ALU_XOR, 2'b10, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b11, 2'b00, 16'h0100, 16'h0023, ALU_ADD,
                          16'h3000, 16'h0300, ALU_OR, 2'b11, 2'b01, 2'b00, 3));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 16'h0000, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b11, 2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b10, 2'b00, 16'h0000, 16'h0000, ALU_ADD,
                          16'h0003, 16'h0005, ALU_CMP, 2'b11, 2'b10, 2'b00, 4));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 16'h0000, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b11, 2'b00, 2'b00, 0));
        vecs.push_back(mk(2'b01, 2'b00, 16'h4444, 16'h1111, ALU_SUB,
                          16'h0000, 16'h0000, ALU_ADD, 2'b11, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b10, 2'b10, 16'h0000, 16'h0000, ALU_ADD,
                          16'h5555, 16'h0F0F, ALU_AND, 2'b10, 2'b10, 2'b00, 0));
        vecs.push_back(mk(2'b01, 2'b00, 16'h0001, 16'h0001, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b00, 2'b00, 2'b10, 5));
        vecs.push_back(mk(2'b11, 2'b00, 16'h00AA, 16'h0055, ALU_ADD,
                          16'h00BB, 16'h0011, ALU_SUB, 2'b11, 2'b01, 2'b00, 0));
        vecs.push_back(mk(2'b00, 2'b00, 16'h0000, 16'h0000, ALU_ADD,
                          16'h0000, 16'h0000, ALU_ADD, 2'b11, 2'b00, 2'b00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
